dpram_param: RTL and testbench
==============================

// Module: dpram_param
// PURPOSE
//  Parametrised single-clock true dual-port block RAM; successor to the fixed 4K x 8 dual-port RAM.
//  Configurable width and depth, per-port write mode, optional output pipeline register,
//  deterministic A-over-B write collision rule and a built-in clear engine.
//  Serves as video/sprite/work RAM for the game core.
// PARAMETERS
//  DATA_W         8     data width per port, bits
//  ADDR_W         12    address width; DEPTH = 2**ADDR_W words
//  WRITE_MODE_A   0     port A write mode: 0 normal, 1 write-through, 2 read-before-write
//  WRITE_MODE_B   0     port B write mode, same encoding as WRITE_MODE_A
//  READ_MODE      0     0 = 1-cycle read latency; 1 = 2-cycle read, second stage gated by oce
//  CLEAR_ON_RESET 1     1 = start clear sweep on the first cycle after reset release
//  CLEAR_VALUE    0     DATA_W value written to every word by the clear sweep
// PORTS
//  clk      in   1       single clock; every event on its rising edge
//  reset_n  in   1       synchronous reset, active-low
//  clr      in   1       single-cycle request to start a clear sweep
//  busy     out  1       1 while the clear sweep is running
//  cea      in   1       port A clock enable
//  wrea     in   1       port A write enable, qualified by cea
//  ocea     in   1       port A output register enable; used only when READ_MODE = 1
//  ada      in   ADDR_W  port A address
//  dina     in   DATA_W  port A write data
//  douta    out  DATA_W  port A read data
//  ceb/wreb/oceb/adb/dinb/doutb  port B, same meanings as port A
// BEHAVIOUR
//  Reset: when reset_n = 0 at an edge:
//   - douta, doutb and both pipeline stages -> 0; busy -> 0; FSM -> IDLE; clear counter -> 0.
//   - Memory contents are not changed by reset.
//  FSM has two states, IDLE and CLEAR:
//   - IDLE -> CLEAR on the first edge with reset_n = 1 after reset, if CLEAR_ON_RESET = 1.
//   - IDLE -> CLEAR on any edge with clr = 1.
//   - In CLEAR: write CLEAR_VALUE to mem[cnt] each cycle; cnt counts up from 0.
//   - CLEAR -> IDLE after the write to DEPTH-1; the sweep takes exactly DEPTH cycles.
//   - busy = 1 for exactly those DEPTH cycles. It rises on the edge that enters CLEAR.
//   - clr during CLEAR is ignored; the sweep does not restart.
//   - reset_n = 0 mid-sweep aborts the sweep. Words already cleared stay cleared.
//     The sweep restarts at 0 after release only if CLEAR_ON_RESET = 1.
//  While busy = 1:
//   - cea and ceb are treated as 0: no user reads or writes.
//   - douta and doutb hold their values.
//  Port access, port enabled (ce = 1, busy = 0):
//   - Read: mem[ad] is captured into stage 1 at the edge.
//   - READ_MODE = 0: dout = stage 1 (1-cycle latency).
//   - READ_MODE = 1: stage 2 <= stage 1 at each edge where oce = 1, otherwise stage 2 holds;
//     dout = stage 2 (2-cycle latency).
//   - ce = 0: stage 1 holds and the port does no write.
//  Write with ce = 1 and wre = 1: mem[ad] <= din. Stage 1 depends on the write mode:
//   - 0 normal: stage 1 holds.
//   - 1 write-through: stage 1 <= din.
//   - 2 read-before-write: stage 1 <= old mem[ad].
//  Collisions:
//   - A and B write the same address in the same cycle: port A data is stored.
//     Each port's stage 1 still follows its own write mode; B's write-through shows dinb.
//   - One port reads an address the other port writes in the same cycle: the reader gets the
//     old data. The new data is visible from the next access.
//  Width rules:
//   - Addresses are used unsigned, with no wrap logic; the full 2**ADDR_W range is valid.
//   - The clear counter is ADDR_W+1 bits to detect the end of the sweep.
// TESTING
//  1 Reset release, CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for exactly 16 cycles.
//    Afterwards every address reads 0x00. douta=0 during reset.
//  2 Write A ad=0x123 din=0xA5, then read B adb=0x123, READ_MODE=0
//    -> doutb=0xA5 one cycle after the read edge.
//  3 READ_MODE=1, read A addr holding 0x3C, ocea=0 for 2 cycles then 1
//    -> douta stays old until the ocea=1 edge, then 0x3C.
//  4 Same-cycle writes A:0x010<-0x11, B:0x010<-0x22 -> a later read returns 0x11.
//    Modes 1/2 preloaded 0x77: write-through port shows the new data (0x11 on A, 0x22 on B);
//    read-before-write port shows 0x77.
//  5 Cross-port: A writes 0x055<-0x99 while B reads 0x055 (old 0x44)
//    -> doutb=0x44; B reads 0x99 next cycle.
//  6 clr pulse, then reset_n=0 at sweep cycle 5, CLEAR_ON_RESET=0 -> busy drops to 0.
//    Addresses 0-4 hold CLEAR_VALUE, address 5+ keep their old data, no restart.

Source files
------------

// File: rtl/dpram_param.sv
// dpram_param: parametrised single-clock true dual-port RAM with write modes, output pipeline and clear sweep
module dpram_param #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 12,
    parameter int WRITE_MODE_A   = 0,
    parameter int WRITE_MODE_B   = 0,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic              i_cea,
    input  logic              i_wrea,
    input  logic              i_ocea,
    input  logic [ADDR_W-1:0] i_ada,
    input  logic [DATA_W-1:0] i_dina,
    output logic [DATA_W-1:0] o_douta,
    input  logic              i_ceb,
    input  logic              i_wreb,
    input  logic              i_oceb,
    input  logic [ADDR_W-1:0] i_adb,
    input  logic [DATA_W-1:0] i_dinb,
    output logic [DATA_W-1:0] o_doutb
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_init;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_s1a, r_s2a, r_s1b, r_s2b;
    logic              w_ena, w_enb, w_clr_wr;
    assign w_ena    = i_cea & ~o_busy;
    assign w_enb    = i_ceb & ~o_busy;
    assign w_clr_wr = i_reset_n & (r_state == CLEAR);
    assign o_douta  = (READ_MODE == 1) ? r_s2a : r_s1a;
    assign o_doutb  = (READ_MODE == 1) ? r_s2b : r_s1b;
    // clear FSM: r_init remembers a pending post-reset sweep until the first released edge
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
            r_cnt   <= '0;
            r_init  <= (CLEAR_ON_RESET != 0);
        end else if (r_state == IDLE) begin
            if (r_init || i_clr) begin
                r_state <= CLEAR;
                o_busy  <= 1'b1;
                r_cnt   <= '0;
                r_init  <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_state <= IDLE;
                o_busy  <= 1'b0;
            end
        end
    end
    // memory: sweep owns the array while busy; A's write is issued last so it wins collisions
    always_ff @(posedge i_clk) begin
        if (w_clr_wr) begin
            r_mem[r_cnt[ADDR_W-1:0]] <= CLEAR_VALUE;
        end else if (i_reset_n) begin
            if (w_enb && i_wreb) r_mem[i_adb] <= i_dinb;
            if (w_ena && i_wrea) r_mem[i_ada] <= i_dina;
        end
    end
    // port A read path: stage 1 follows the write mode, stage 2 advances on ocea
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1a <= '0;
            r_s2a <= '0;
        end else if (!o_busy) begin
            if (i_cea) r_s1a <= (!i_wrea || WRITE_MODE_A == 2) ? r_mem[i_ada] : (WRITE_MODE_A == 1) ? i_dina : r_s1a;
            if (i_ocea) r_s2a <= r_s1a;
        end
    end
    // port B read path: stage 1 follows the write mode, stage 2 advances on oceb
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1b <= '0;
            r_s2b <= '0;
        end else if (!o_busy) begin
            if (i_ceb) r_s1b <= (!i_wreb || WRITE_MODE_B == 2) ? r_mem[i_adb] : (WRITE_MODE_B == 1) ? i_dinb : r_s1b;
            if (i_oceb) r_s2b <= r_s1b;
        end
    end
endmodule

// File: tb/tb_dpram_param.sv
// tb_dpram_param: directed table-driven checks of dpram_param across three configurations
module tb_dpram_param;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr = 1'b0;
    logic        cea = 1'b0, wrea = 1'b0, oca = 1'b1;
    logic        ceb = 1'b0, wreb = 1'b0, ocb = 1'b1;
    logic [11:0] ada = '0, adb = '0;
    logic [7:0]  dina = '0, dinb = '0;
    logic        busy0, busy1, busy2;
    logic [7:0]  da0, db0, da1, db1, da2, db2;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    dpram_param #(.ADDR_W(4), .CLEAR_ON_RESET(1)) u0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clr(clr), .o_busy(busy0),
        .i_cea(cea), .i_wrea(wrea), .i_ocea(oca), .i_ada(ada[3:0]), .i_dina(dina), .o_douta(da0),
        .i_ceb(ceb), .i_wreb(wreb), .i_oceb(ocb), .i_adb(adb[3:0]), .i_dinb(dinb), .o_doutb(db0));

    dpram_param #(.ADDR_W(12), .WRITE_MODE_A(1), .WRITE_MODE_B(2), .READ_MODE(0),
                  .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'hEE)) u1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clr(clr), .o_busy(busy1),
        .i_cea(cea), .i_wrea(wrea), .i_ocea(oca), .i_ada(ada), .i_dina(dina), .o_douta(da1),
        .i_ceb(ceb), .i_wreb(wreb), .i_oceb(ocb), .i_adb(adb), .i_dinb(dinb), .o_doutb(db1));

    dpram_param #(.ADDR_W(12), .WRITE_MODE_A(2), .WRITE_MODE_B(1), .READ_MODE(1),
                  .CLEAR_ON_RESET(0)) u2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clr(clr), .o_busy(busy2),
        .i_cea(cea), .i_wrea(wrea), .i_ocea(oca), .i_ada(ada), .i_dina(dina), .o_douta(da2),
        .i_ceb(ceb), .i_wreb(wreb), .i_oceb(ocb), .i_adb(adb), .i_dinb(dinb), .o_doutb(db2));

    typedef struct {
        logic       ca, wa;
        logic [11:0] aa;
        logic [7:0] da;
        logic       cb, wb;
        logic [11:0] ab;
        logic [7:0] db;
        logic       ka, kb;
        logic [7:0] ea, eb;
    } vec_t;

    vec_t tv [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic ca_, input logic wa_, input logic [11:0] aa_, input logic [7:0] da_,
                         input logic cb_, input logic wb_, input logic [11:0] ab_, input logic [7:0] db_);
        cea = ca_; wrea = wa_; ada = aa_; dina = da_;
        ceb = cb_; wreb = wb_; adb = ab_; dinb = db_;
    endtask

    initial begin
        int cnt;
        tv[0]  = '{1, 1, 12'h123, 8'hA5, 0, 0, 12'h000, 8'h00, 1, 0, 8'hA5, 8'h00};
        tv[1]  = '{0, 0, 12'h000, 8'h00, 1, 0, 12'h123, 8'h00, 1, 1, 8'hA5, 8'hA5};
        tv[2]  = '{1, 1, 12'h010, 8'h77, 0, 0, 12'h000, 8'h00, 1, 1, 8'h77, 8'hA5};
        tv[3]  = '{1, 1, 12'h010, 8'h11, 1, 1, 12'h010, 8'h22, 1, 1, 8'h11, 8'h77};
        tv[4]  = '{1, 0, 12'h010, 8'h00, 1, 0, 12'h010, 8'h00, 1, 1, 8'h11, 8'h11};
        tv[5]  = '{0, 0, 12'h000, 8'h00, 1, 1, 12'h055, 8'h44, 1, 0, 8'h11, 8'h00};
        tv[6]  = '{1, 1, 12'h055, 8'h99, 1, 0, 12'h055, 8'h00, 1, 1, 8'h99, 8'h44};
        tv[7]  = '{0, 0, 12'h000, 8'h00, 1, 0, 12'h055, 8'h00, 1, 1, 8'h99, 8'h99};
        tv[8]  = '{1, 0, 12'h123, 8'h00, 1, 0, 12'h010, 8'h00, 1, 1, 8'hA5, 8'h11};
        tv[9]  = '{1, 1, 12'hFFF, 8'h5A, 1, 1, 12'h000, 8'hC3, 1, 0, 8'h5A, 8'h00};
        tv[10] = '{1, 0, 12'h000, 8'h00, 1, 0, 12'hFFF, 8'h00, 1, 1, 8'hC3, 8'h5A};
        tv[11] = '{0, 1, 12'h000, 8'hFF, 0, 1, 12'hFFF, 8'hFF, 1, 1, 8'hC3, 8'h5A};
        tv[12] = '{1, 0, 12'h000, 8'h00, 1, 0, 12'hFFF, 8'h00, 1, 1, 8'hC3, 8'h5A};

        // reset values and post-reset clear sweep on the 16-word instance
        repeat (3) tick();
        chk("rst_douta0", da0, 8'h00);
        chk("rst_doutb0", db0, 8'h00);
        chk("rst_busy0", {7'd0, busy0}, 8'h00);
        chk("rst_douta2", da2, 8'h00);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy0) cnt++;
            else if (cnt > 0) break;
        end
        chk("sweep_len", 8'(cnt), 8'd16);
        chk("busy1_no_autoclr", {7'd0, busy1}, 8'h00);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 12'(i), 8'h00, 0, 0, 12'h000, 8'h00);
            tick();
            chk($sformatf("cleared_%0d", i), da0, 8'h00);
        end

        // table of single-cycle vectors against the WT/RBW instance
        for (int i = 0; i < 13; i++) begin
            drive(tv[i].ca, tv[i].wa, tv[i].aa, tv[i].da, tv[i].cb, tv[i].wb, tv[i].ab, tv[i].db);
            tick();
            if (tv[i].ka) chk($sformatf("vec%0d_douta", i), da1, tv[i].ea);
            if (tv[i].kb) chk($sformatf("vec%0d_doutb", i), db1, tv[i].eb);
        end

        // collision with swapped modes on the pipelined instance
        drive(1, 1, 12'h020, 8'h77, 0, 0, 12'h000, 8'h00);
        tick();
        drive(1, 1, 12'h020, 8'h11, 1, 1, 12'h020, 8'h22);
        tick();
        chk("coll_u1_douta_wt", da1, 8'h11);
        chk("coll_u1_doutb_rbw", db1, 8'h77);
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        chk("coll_u2_douta_rbw", da2, 8'h77);
        chk("coll_u2_doutb_wt", db2, 8'h22);
        drive(1, 0, 12'h020, 8'h00, 1, 0, 12'h020, 8'h00);
        tick();
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        chk("coll_u2_a_wins_a", da2, 8'h11);
        chk("coll_u2_a_wins_b", db2, 8'h11);

        // READ_MODE=1 output register gated by ocea
        drive(1, 1, 12'h030, 8'h3C, 0, 0, 12'h000, 8'h00);
        tick();
        drive(1, 0, 12'h020, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        chk("oce_prime", da2, 8'h11);
        oca = 1'b0;
        drive(1, 0, 12'h030, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        chk("oce_hold1", da2, 8'h11);
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        tick();
        chk("oce_hold2", da2, 8'h11);
        oca = 1'b1;
        tick();
        chk("oce_advance", da2, 8'h3C);

        // clr sweep aborted by reset at sweep cycle 5, no restart without CLEAR_ON_RESET
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 12'(i), 8'(8'h40 + i), 0, 0, 12'h000, 8'h00);
            tick();
        end
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1, 1, 12'h006, 8'hFF, 0, 0, 12'h000, 8'h00);
        chk("clr_busy_rise", {7'd0, busy1}, 8'h01);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("busy_dout_hold", da1, 8'h47);
        tick();
        tick();
        chk("busy_before_abort", {7'd0, busy1}, 8'h01);
        drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
        reset_n = 1'b0;
        tick();
        chk("abort_busy", {7'd0, busy1}, 8'h00);
        chk("abort_douta", da1, 8'h00);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("no_restart", {7'd0, busy1}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 12'h000, 8'h00, 1, 0, 12'(i), 8'h00);
            tick();
            chk($sformatf("abort_word_%0d", i), db1, (i < 5) ? 8'hEE : 8'(8'h40 + i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
